seq_gen_lrr: RTL

- Parametrised linear-recurrence sequence generator: term(x) = sum over selected taps of term(x-1-k), k = 0..ORDER-1, modulo 2^WIDTH.
- Runtime-programmable tap mask and seed history.
- Output uses a valid/ready stream handshake, with optional automatic stop after MAX_TERMS terms.
- Sits as a stream source feeding downstream datapath/test logic; successor to the fixed two-tap 32-bit generator.

---
 rtl/seq_gen_pkg.sv | 19 +
 rtl/seq_tap_sum.sv | 34 +++
 rtl/seq_gen_lrr.sv | 136 +++++++++++++
 3 files changed

// File: rtl/seq_gen_pkg.sv
// Shared types and width helpers for the linear-recurrence sequence generator.
package seq_gen_pkg;

   typedef enum logic [0:0] {
      S_IDLE,
      S_RUN
   } state_e;

   // Width of the history index port: max(1, clog2(order)).
   function automatic int idx_w(input int order);
      return ($clog2(order) > 1) ? $clog2(order) : 1;
   endfunction

   // Width at which the tap sum is formed so that no carry is lost.
   function automatic int sum_w(input int width, input int order);
      return width + $clog2(order) + 1;
   endfunction

endpackage

// File: rtl/seq_tap_sum.sv
// Combinational tap adder: sums the history words selected by the tap mask
// at full width, returns the low WIDTH bits and a flag for any higher bit.
module seq_tap_sum
   import seq_gen_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ORDER = 4
) (
   input  logic [ORDER*WIDTH-1:0] hist_i,
   input  logic [ORDER-1:0]       taps_i,
   output logic [WIDTH-1:0]       sum_o,
   output logic                   carry_o
);

   localparam int SUM_W = sum_w(WIDTH, ORDER);

   logic [SUM_W-1:0] acc;

   // Accumulate every selected history word into a carry-safe sum.
   always_comb begin
      // NOTE: a default assignment ahead of the loop keeps this purely
      // combinational; without it the tool would infer a latch on acc.
      acc = '0;
      for (int k = 0; k < ORDER; k++) begin
         if (taps_i[k]) begin
            acc = acc + SUM_W'(hist_i[k*WIDTH +: WIDTH]);
         end
      end
   end

   assign sum_o   = acc[WIDTH-1:0];
   assign carry_o = |acc[SUM_W-1:WIDTH];

endmodule

// File: rtl/seq_gen_lrr.sv
// Linear-recurrence sequence source with programmable taps and seed history,
// a valid/ready output stream and optional auto-stop after MAX_TERMS terms.
module seq_gen_lrr
   import seq_gen_pkg::*;
#(
   parameter int               WIDTH        = 32,
   parameter int               ORDER        = 4,
   parameter int               MAX_TERMS    = 0,
   parameter logic [WIDTH-1:0] SEED_DEFAULT = {{(WIDTH-1){1'b0}}, 1'b1},
   localparam int              IDX_W        = idx_w(ORDER)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic [ORDER-1:0] taps_i,
   input  logic             seed_we,
   input  logic [IDX_W-1:0] seed_idx,
   input  logic [WIDTH-1:0] seed_data,
   output logic [WIDTH-1:0] seq_o,
   output logic             seq_valid,
   input  logic             seq_ready,
   output logic [31:0]      count_o,
   output logic             ovf_o,
   output logic             done_o,
   output logic             busy_o
);

   state_e             state_q;
   logic [WIDTH-1:0]   hist_q [ORDER];
   logic [ORDER-1:0]   taps_q;
   logic [31:0]        count_q;
   logic [31:0]        count_d;
   logic               valid_q;
   logic               busy_q;
   logic               ovf_q;
   logic               done_q;

   logic [ORDER*WIDTH-1:0] hist_flat;
   logic [WIDTH-1:0]       term_d;
   logic                   carry;
   logic                   fire;
   logic                   last_fire;

   // Flatten the history array for the tap adder.
   always_comb begin
      hist_flat = '0;
      for (int k = 0; k < ORDER; k++) begin
         hist_flat[k*WIDTH +: WIDTH] = hist_q[k];
      end
   end

   seq_tap_sum #(
      .WIDTH (WIDTH),
      .ORDER (ORDER)
   ) u_tap_sum (
      .hist_i  (hist_flat),
      .taps_i  (taps_q),
      .sum_o   (term_d),
      .carry_o (carry)
   );

   assign fire      = valid_q & seq_ready;
   assign count_d   = count_q + 32'd1;
   assign last_fire = fire && (MAX_TERMS != 0) && (count_d == 32'(MAX_TERMS));

   // FSM, history shift register, seed port, term counter and flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         taps_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         // NOTE: the history is architectural state (it defines the next
         // run's terms), so unlike a data buffer it must be reset.
         for (int k = 0; k < ORDER; k++) begin
            hist_q[k] <= SEED_DEFAULT;
         end
      end else begin
         // NOTE: non-blocking assignments throughout so every register here
         // samples pre-edge values regardless of statement order.
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               for (int k = 0; k < ORDER; k++) begin
                  if (seed_we && (seed_idx == IDX_W'(k))) begin
                     hist_q[k] <= seed_data;
                  end
               end
               if (start) begin
                  state_q <= S_RUN;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
                  taps_q  <= taps_i;
                  count_q <= '0;
                  ovf_q   <= 1'b0;
               end
            end
            S_RUN: begin
               if (fire) begin
                  hist_q[0] <= term_d;
                  for (int k = 1; k < ORDER; k++) begin
                     hist_q[k] <= hist_q[k-1];
                  end
                  count_q <= count_d;
                  if (carry) begin
                     ovf_q <= 1'b1;
                  end
               end
               if (stop || last_fire) begin
                  state_q <= S_IDLE;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= last_fire;
               end
            end
            default: begin
               state_q <= S_IDLE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign seq_o     = hist_q[0];
   assign seq_valid = valid_q;
   assign busy_o    = busy_q;
   assign count_o   = count_q;
   assign ovf_o     = ovf_q;
   assign done_o    = done_q;

endmodule
